// File: rtl/varredor_tabuleiro.sv
// Row-by-row scanner for the 8x8 chessboard sensor matrix: debounces a single
// pressed square and presents it as a level-type move to the game datapath.
module varredor_tabuleiro #(
    parameter int LINHAS   = 8,
    parameter int COLUNAS  = 8,
    parameter int T_LINHA  = 50,
    parameter int DEBOUNCE = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               habilita,
    input  logic [COLUNAS-1:0] colunasSensor,
    output logic [LINHAS-1:0]  linhasVarredura,
    output logic [3:0]         jogadaLinha,
    output logic [3:0]         jogadaColuna,
    output logic               jogou,
    output logic               multipla,
    output logic [2:0]         db_estado
);

    localparam int LW = (LINHAS > 1) ? $clog2(LINHAS) : 1;
    localparam int DW = (T_LINHA > 1) ? $clog2(T_LINHA) : 1;
    localparam int EW = $clog2(DEBOUNCE + 1);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        VARRE  = 3'd1,
        AVALIA = 3'd2
    } estado_t;

    estado_t       estado, estadoProx;
    logic [LW-1:0] linha, linhaProx;
    logic [DW-1:0] dwell, dwellProx;
    logic [1:0]    contagem, contagemProx;
    logic          hitValido, hitValidoProx;
    logic [3:0]    hitLinha, hitLinhaProx, hitColuna, hitColunaProx;
    logic [3:0]    candLinha, candLinhaProx, candColuna, candColunaProx;
    logic [EW-1:0] estavel, estavelProx, vazio, vazioProx;
    logic [3:0]    jogadaLinhaProx, jogadaColunaProx;
    logic          jogouProx;

    logic [1:0]    pressionados;
    logic [3:0]    primeiraColuna;
    logic          algumPressionado;

    function automatic logic [EW-1:0] satInc(input logic [EW-1:0] v);
        return (v >= EW'(DEBOUNCE)) ? EW'(DEBOUNCE) : v + 1'b1;
    endfunction

    function automatic logic [1:0] satSoma(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s >= 3'd2) ? 2'd2 : s[1:0];
    endfunction

    // Count pressed columns (saturating at 2) and find the lowest pressed one.
    always_comb begin
        pressionados     = 2'd0;
        primeiraColuna   = 4'd0;
        algumPressionado = 1'b0;
        for (int c = COLUNAS - 1; c >= 0; c--) begin
            if (colunasSensor[c]) begin
                primeiraColuna   = 4'(c);
                algumPressionado = 1'b1;
                pressionados     = satSoma(pressionados, 2'd1);
            end
        end
    end

    always_comb begin
        estadoProx       = estado;
        linhaProx        = linha;
        dwellProx        = dwell;
        contagemProx     = contagem;
        hitValidoProx    = hitValido;
        hitLinhaProx     = hitLinha;
        hitColunaProx    = hitColuna;
        candLinhaProx    = candLinha;
        candColunaProx   = candColuna;
        estavelProx      = estavel;
        vazioProx        = vazio;
        jogadaLinhaProx  = jogadaLinha;
        jogadaColunaProx = jogadaColuna;
        jogouProx        = jogou;
        multipla         = 1'b0;

        case (estado)
            OCIOSO: begin
                if (habilita) begin
                    estadoProx    = VARRE;
                    linhaProx     = '0;
                    dwellProx     = '0;
                    contagemProx  = 2'd0;
                    hitValidoProx = 1'b0;
                end
            end
            VARRE: begin
                if (dwell == DW'(T_LINHA - 1)) begin
                    dwellProx    = '0;
                    contagemProx = satSoma(contagem, pressionados);
                    if (!hitValido && algumPressionado) begin
                        hitValidoProx = 1'b1;
                        hitLinhaProx  = 4'(linha);
                        hitColunaProx = primeiraColuna;
                    end
                    if (linha == LW'(LINHAS - 1)) begin
                        linhaProx  = '0;
                        estadoProx = AVALIA;
                    end else begin
                        linhaProx = linha + 1'b1;
                    end
                end else begin
                    dwellProx = dwell + 1'b1;
                end
            end
            AVALIA: begin
                if (contagem == 2'd1) begin
                    vazioProx = '0;
                    if (hitLinha == candLinha && hitColuna == candColuna) begin
                        estavelProx = satInc(estavel);
                    end else begin
                        candLinhaProx  = hitLinha;
                        candColunaProx = hitColuna;
                        estavelProx    = EW'(1);
                    end
                end else if (contagem >= 2'd2) begin
                    multipla    = 1'b1;
                    estavelProx = '0;
                    vazioProx   = '0;
                end else begin
                    vazioProx   = satInc(vazio);
                    estavelProx = '0;
                end
                // A held move is locked until a full release is seen.
                if (!jogou && estavelProx == EW'(DEBOUNCE)) begin
                    jogadaLinhaProx  = candLinhaProx;
                    jogadaColunaProx = candColunaProx;
                    jogouProx        = 1'b1;
                end else if (jogou && vazioProx == EW'(DEBOUNCE)) begin
                    jogouProx = 1'b0;
                end
                contagemProx  = 2'd0;
                hitValidoProx = 1'b0;
                estadoProx    = VARRE;
            end
            default: estadoProx = OCIOSO;
        endcase

        if (!habilita) begin
            estadoProx  = OCIOSO;
            jogouProx   = 1'b0;
            estavelProx = '0;
            vazioProx   = '0;
            multipla    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= OCIOSO;
            linha        <= '0;
            dwell        <= '0;
            contagem     <= 2'd0;
            hitValido    <= 1'b0;
            hitLinha     <= 4'd0;
            hitColuna    <= 4'd0;
            candLinha    <= 4'd0;
            candColuna   <= 4'd0;
            estavel      <= '0;
            vazio        <= '0;
            jogadaLinha  <= 4'd0;
            jogadaColuna <= 4'd0;
            jogou        <= 1'b0;
        end else begin
            estado       <= estadoProx;
            linha        <= linhaProx;
            dwell        <= dwellProx;
            contagem     <= contagemProx;
            hitValido    <= hitValidoProx;
            hitLinha     <= hitLinhaProx;
            hitColuna    <= hitColunaProx;
            candLinha    <= candLinhaProx;
            candColuna   <= candColunaProx;
            estavel      <= estavelProx;
            vazio        <= vazioProx;
            jogadaLinha  <= jogadaLinhaProx;
            jogadaColuna <= jogadaColunaProx;
            jogou        <= jogouProx;
        end
    end

    always_comb begin
        linhasVarredura = '0;
        if (estado == VARRE) begin
            linhasVarredura[linha] = 1'b1;
        end
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_varredor_tabuleiro.sv
// Bench for varredor_tabuleiro: a physical board model feeds the column lines and
// a frame-level model of the debounce rules predicts the move outputs.
module tb_varredor_tabuleiro;

    localparam int T  = 4;
    localparam int DB = 3;
    localparam int CICLOS_QUADRO = 8 * T + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       habilita = 1'b0;
    logic [7:0] colunasSensor = 8'd0;
    logic [7:0] linhasVarredura;
    logic [3:0] jogadaLinha, jogadaColuna;
    logic       jogou, multipla;
    logic [2:0] db_estado;

    int total = 0;
    int falhas = 0;

    logic [7:0] tabuleiro [8];

    int mCandL = 0, mCandC = 0, mEstavel = 0, mVazio = 0;
    int mJogou = 0, mJL = 0, mJC = 0;

    varredor_tabuleiro #(
        .LINHAS(8), .COLUNAS(8), .T_LINHA(T), .DEBOUNCE(DB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .habilita(habilita),
        .colunasSensor(colunasSensor),
        .linhasVarredura(linhasVarredura),
        .jogadaLinha(jogadaLinha),
        .jogadaColuna(jogadaColuna),
        .jogou(jogou),
        .multipla(multipla),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            falhas++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic limpa();
        for (int r = 0; r < 8; r++) tabuleiro[r] = 8'd0;
    endtask

    task automatic aperta(input int l, input int c);
        tabuleiro[l][c] = 1'b1;
    endtask

    function automatic logic [7:0] sensorDe(input logic [7:0] linhas);
        logic [7:0] s;
        s = 8'd0;
        for (int r = 0; r < 8; r++) if (linhas[r]) s = s | tabuleiro[r];
        return s;
    endfunction

    task automatic contaQuadro(output int n, output int fl, output int fc);
        n = 0; fl = 0; fc = 0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (tabuleiro[r][c]) begin
                    if (n == 0) begin fl = r; fc = c; end
                    n++;
                end
    endtask

    task automatic aplicaModelo(input int n, input int fl, input int fc);
        if (n == 1) begin
            mVazio = 0;
            if (fl == mCandL && fc == mCandC) mEstavel = (mEstavel + 1 > DB) ? DB : mEstavel + 1;
            else begin mCandL = fl; mCandC = fc; mEstavel = 1; end
        end else if (n >= 2) begin
            mEstavel = 0; mVazio = 0;
        end else begin
            mVazio = (mVazio + 1 > DB) ? DB : mVazio + 1;
            mEstavel = 0;
        end
        if (mJogou == 0 && mEstavel == DB) begin
            mJL = mCandL; mJC = mCandC; mJogou = 1;
        end else if (mJogou == 1 && mVazio == DB) begin
            mJogou = 0;
        end
    endtask

    // One full frame, starting on the first VARRE cycle of row 0.
    task automatic quadro();
        int n, fl, fc;
        logic [7:0] esperado;
        contaQuadro(n, fl, fc);
        for (int i = 0; i < CICLOS_QUADRO; i++) begin
            @(negedge clock);
            if (i == 0) begin
                chk("jogou", jogou, mJogou);
                chk("jogadaLinha", jogadaLinha, mJL);
                chk("jogadaColuna", jogadaColuna, mJC);
            end
            esperado = (i < 8 * T) ? (8'd1 << (i / T)) : 8'd0;
            chk("linhasVarredura", linhasVarredura, esperado);
            chk("multipla", multipla, (i == 8 * T && n >= 2) ? 1 : 0);
            if (i == 8 * T) begin
                chk("db_estado_avalia", db_estado, 2);
                chk("jogou_avalia", jogou, mJogou);
            end else if (i == 1) begin
                chk("db_estado_varre", db_estado, 1);
            end
            colunasSensor = sensorDe(linhasVarredura);
        end
        aplicaModelo(n, fl, fc);
    endtask

    task automatic quadros(input int k);
        for (int q = 0; q < k; q++) quadro();
    endtask

    task automatic parcial(input int ciclos);
        for (int i = 0; i < ciclos; i++) begin
            @(negedge clock);
            chk("linhas_parcial", linhasVarredura, 8'd1 << (i / T));
            colunasSensor = sensorDe(linhasVarredura);
        end
    endtask

    task automatic checaZero(input string tag);
        chk({tag, "_linhas"}, linhasVarredura, 0);
        chk({tag, "_jogadaLinha"}, jogadaLinha, 0);
        chk({tag, "_jogadaColuna"}, jogadaColuna, 0);
        chk({tag, "_jogou"}, jogou, 0);
        chk({tag, "_multipla"}, multipla, 0);
        chk({tag, "_estado"}, db_estado, 0);
    endtask

    initial begin
        int l1, c1, l2, c2;
        limpa();
        habilita = 1'b1;
        #1 reset = 1'b1;
        @(negedge clock);
        checaZero("reset");
        @(negedge clock);
        reset = 1'b0;

        // Single press, then release: hold and release latency.
        aperta(2, 5);
        quadros(4);
        limpa();
        quadros(4);

        // Bounce on (7,0).
        aperta(7, 0); quadros(2);
        limpa();      quadros(1);
        aperta(7, 0); quadros(4);
        limpa();      quadros(4);

        // Two squares together, then one released.
        aperta(1, 1); aperta(4, 6); quadros(5);
        limpa(); aperta(1, 1); quadros(4);
        limpa(); quadros(4);

        // Move while held is ignored until release.
        aperta(3, 3); quadros(4);
        limpa(); aperta(6, 2); quadros(4);
        limpa(); quadros(4);

        // Randomised boards.
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 5))
                0: limpa();
                1, 2: begin
                    limpa();
                    l1 = $urandom_range(0, 7); c1 = $urandom_range(0, 7);
                    aperta(l1, c1);
                end
                3: begin
                    limpa();
                    l1 = $urandom_range(0, 7); c1 = $urandom_range(0, 7);
                    l2 = $urandom_range(0, 7); c2 = $urandom_range(0, 7);
                    aperta(l1, c1); aperta(l2, c2);
                end
                default: ;
            endcase
            quadro();
        end

        // Enable dropped mid-frame with a move held.
        limpa(); quadros(3);
        aperta(5, 4); quadros(4);
        parcial(10);
        habilita = 1'b0;
        @(negedge clock);
        mJogou = 0; mEstavel = 0; mVazio = 0;
        chk("hab_linhas", linhasVarredura, 0);
        chk("hab_jogou", jogou, 0);
        chk("hab_estado", db_estado, 0);
        chk("hab_jogadaLinha", jogadaLinha, mJL);
        chk("hab_jogadaColuna", jogadaColuna, mJC);
        colunasSensor = 8'd0;
        @(negedge clock);
        chk("hab_estado2", db_estado, 0);
        habilita = 1'b1;
        quadros(4);

        // Asynchronous reset in the middle of a scan.
        parcial(7);
        #2 reset = 1'b1;
        #1 checaZero("reset_async");
        mCandL = 0; mCandC = 0; mEstavel = 0; mVazio = 0;
        mJogou = 0; mJL = 0; mJC = 0;
        @(negedge clock);
        colunasSensor = 8'd0;
        reset = 1'b0;
        quadros(4);

        $display("End of test - %0d assertions evaluated, %0d failures", total, falhas);
        $finish;
    end

endmodule

// File: doc/varredor_tabuleiro.md
Name: varredor_tabuleiro

Overview:
- Scans the 8x8 sensor matrix of the physical chessboard one row at a time.
- Debounces the single square the player presses and presents it as jogadaLinha/jogadaColuna with a level-type jogou flag.
- Output side feeds the game datapath directly: that datapath registers the move and edge-detects jogou.
- Sits between board I/O pins and the datapath; it is the producing end of the move-input interface.

Parameters:
- LINHAS, 8, number of board rows scanned (max 16).
- COLUNAS, 8, number of column sense lines (max 16).
- T_LINHA, 50, clock cycles each row stays driven; columns are sampled on the last cycle.
- DEBOUNCE, 3, consecutive identical frames required to accept a press or a release.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high; clears all state.
- habilita  in  1  scan enable.
- colunasSensor  in  COLUNAS  column sense lines; active-high = square pressed in the currently driven row; already synchronised externally.
- linhasVarredura  out  LINHAS  one-hot row drive; all zero when idle.
- jogadaLinha  out  4  accepted row index, 0-based.
- jogadaColuna  out  4  accepted column index, 0-based.
- jogou  out  1  high while an accepted press is held.
- multipla  out  1  pulse, 1 cycle: the frame just ended saw 2 or more pressed squares.
- db_estado  out  3  FSM state code.

Behaviour:
- Reset values: linhasVarredura=0, jogadaLinha=0, jogadaColuna=0, jogou=0, multipla=0, db_estado=OCIOSO. All internal counters and candidate registers are 0.

FSM states and transitions:
- OCIOSO(0): habilita=1 -> VARRE, with row=0 and dwell=0.
- VARRE(1): drives linhasVarredura = 1<<row.
  - Dwell counter runs 0..T_LINHA-1.
  - On dwell=T_LINHA-1, colunasSensor is sampled: pressed bits are added to the frame count (saturating at 2), and the first hit is recorded.
  - First-hit priority: lowest row, then lowest column.
  - Then row increments; after row LINHAS-1 -> AVALIA, and row wraps to 0.
- AVALIA(2): 1 cycle; linhasVarredura=0. The frame result is applied as follows.
  - count=1, square equal to the stored candidate: estavel increments, saturating at DEBOUNCE.
  - count=1, square different: the square becomes the candidate and estavel=1.
  - count>=2: multipla=1 this cycle; estavel=0; candidate is unchanged; jogou is unchanged.
  - count=0: vazio increments, saturating at DEBOUNCE; estavel=0.
  - Any nonzero count clears vazio.
  - If jogou=0 and estavel reaches DEBOUNCE: candidate is copied to jogadaLinha/jogadaColuna and jogou=1, both from the next cycle.
  - If jogou=1 and vazio reaches DEBOUNCE: jogou=0, and jogadaLinha/jogadaColuna hold their value.
  - While jogou=1, a different single square does not change the outputs. Release (DEBOUNCE empty frames) is required first.
  - Then -> VARRE for the next frame.
- habilita=0 in any state: -> OCIOSO next cycle. linhasVarredura=0, jogou=0, estavel=vazio=0; jogadaLinha/jogadaColuna hold.

Timing:
- Frame = LINHAS*T_LINHA + 1 cycles.
- Minimum press latency = DEBOUNCE full frames from the first frame that sees the square, plus 1 cycle.
- No row overlap: exactly one bit of linhasVarredura is high in VARRE, zero bits otherwise.

Widths:
- Indices are zero-extended to 4 bits.
- Counters are sized with $clog2 of their limits.

Asynchronous reset mid-frame: returns to OCIOSO immediately with all outputs at reset values.

Test Plan:
1. Bench overrides T_LINHA=4, DEBOUNCE=3, giving a 33-cycle frame. Hold row 2 / column 5 pressed from reset release -> jogou rises at the end of the 3rd AVALIA with jogadaLinha=2, jogadaColuna=5; linhasVarredura walks 0x01..0x80, 4 cycles per row.
2. After test 1, release all squares -> jogou falls after 3 empty frames; jogadaLinha/Coluna stay 2/5.
3. Bounce: square (7,0) pressed for frames 1-2, empty in frame 3, pressed again for frames 4-6 -> no jogou until the end of frame 6, then jogadaLinha=7, jogadaColuna=0.
4. Press (1,1) and (4,6) together for 5 frames -> multipla pulses once per AVALIA, jogou stays 0. Release (4,6) -> jogou rises 3 frames later with (1,1).
5. With jogou=1 on (3,3), move the press to (6,2) with no gap -> outputs stay (3,3) and jogou stays 1 until 3 empty frames occur.
6. Drop habilita mid-frame -> next cycle linhasVarredura=0, jogou=0, db_estado=0. Assert reset mid-VARRE -> all outputs zero immediately, asynchronously.
